// File: rtl/uart_tx_fifo.sv
// UART transmitter with a DEPTH-entry transmit FIFO and per-frame latched format.
// Optional parity support is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_en_i,
  input  logic [15:0]      clks_per_bit_i,
  input  logic [1:0]       data_bits_i,
  input  logic [1:0]       parity_i,
  input  logic             stop2_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             in_ready_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t           state, state_n;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [LVL_W-1:0] level_n;
  logic [15:0]      cnt, cnt_n, n_lat;
  logic [2:0]       idx, idx_n, last_idx;
  logic             stop_idx, stop_idx_n;
  logic [1:0]       d_lat;
  logic             stop2_lat;
  logic [7:0]       shreg, data_n;
  logic             push, load, bit_end, frame_end, done_n, tx_n;

`ifdef UART_TX_PARITY_EN
  logic [1:0] par_lat;
  logic       par_en;

  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] dbits,
                                      input logic odd);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - dbits);
    return (^(d & mask)) ^ odd;
  endfunction

  assign par_en = (par_lat == 2'b01) || (par_lat == 2'b10);
`else
  logic unused_parity;
  assign unused_parity = ^parity_i;
`endif

  assign push      = in_valid_i && in_ready_o;
  assign bit_end   = (cnt == (n_lat - 16'd1));
  assign last_idx  = {1'b0, d_lat} + 3'd4;
  assign frame_end = (state == STOP) && bit_end && (!stop2_lat || stop_idx);
  // Load happens from IDLE or exactly at the end of the last stop bit, so frames chain gap-free.
  assign load      = tx_en_i && (level_o != '0) && ((state == IDLE) || frame_end);
  assign data_n    = load ? mem[rptr] : shreg;

  // FIFO occupancy bookkeeping
  always_comb begin
    level_n = level_o;
    case ({push, load})
      2'b10:   level_n = level_o + 1'b1;
      2'b01:   level_n = level_o - 1'b1;
      default: level_n = level_o;
    endcase
  end

  // Frame sequencer next-state and next-output logic
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    stop_idx_n = stop_idx;
    done_n     = 1'b0;
    tx_n       = 1'b1;
    if (bit_end) begin
      cnt_n = 16'd0;
    end else begin
      cnt_n = cnt + 16'd1;
    end
    case (state)
      IDLE: begin
        cnt_n      = 16'd0;
        idx_n      = 3'd0;
        stop_idx_n = 1'b0;
        if (load) state_n = START;
        else      state_n = IDLE;
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          idx_n   = 3'd0;
        end else begin
          state_n = START;
        end
      end
      DATA: begin
        if (bit_end && (idx == last_idx)) begin
          idx_n = 3'd0;
`ifdef UART_TX_PARITY_EN
          state_n = par_en ? PARITY : STOP;
`else
          state_n = STOP;
`endif
        end else if (bit_end) begin
          idx_n = idx + 3'd1;
        end else begin
          idx_n = idx;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_n = STOP;
        else         state_n = PARITY;
      end
`endif
      STOP: begin
        if (frame_end) begin
          done_n     = 1'b1;
          stop_idx_n = 1'b0;
          state_n    = load ? START : IDLE;
        end else if (bit_end) begin
          stop_idx_n = 1'b1;
        end else begin
          stop_idx_n = stop_idx;
        end
      end
      default: begin
        state_n    = IDLE;
        cnt_n      = 16'd0;
        idx_n      = 3'd0;
        stop_idx_n = 1'b0;
      end
    endcase
    case (state_n)
      IDLE:    tx_n = 1'b1;
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_n[idx_n];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = parity_bit(shreg, d_lat, par_lat[1]);
`endif
      STOP:    tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
  end

  // FIFO storage, not reset
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= in_data_i;
  end

  // Sequencer, latched frame format, FIFO pointers and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      idx        <= 3'd0;
      stop_idx   <= 1'b0;
      n_lat      <= 16'd1;
      d_lat      <= 2'd0;
      stop2_lat  <= 1'b0;
      shreg      <= 8'd0;
`ifdef UART_TX_PARITY_EN
      par_lat    <= 2'd0;
`endif
      wptr       <= '0;
      rptr       <= '0;
      level_o    <= '0;
      in_ready_o <= 1'b1;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      stop_idx   <= stop_idx_n;
      level_o    <= level_n;
      in_ready_o <= (level_n != LVL_W'(DEPTH));
      tx_o       <= tx_n;
      busy_o     <= (state_n != IDLE);
      done_o     <= done_n;
      if (push) wptr <= wptr + 1'b1;
      if (load) begin
        rptr      <= rptr + 1'b1;
        shreg     <= mem[rptr];
        n_lat     <= (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
        d_lat     <= data_bits_i;
        stop2_lat <= stop2_i;
`ifdef UART_TX_PARITY_EN
        par_lat   <= parity_i;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: expected frame waveforms are queued at stimulus
// time; a monitor captures each frame from tx_o and compares it on every done_o pulse.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst, tx_en, stop2, in_valid, in_ready, tx, busy, done;
  logic [15:0] cpb;
  logic [1:0]  dbits, parity;
  logic [7:0]  in_data;
  logic [2:0]  level;

  typedef struct {
    logic [255:0] wave;
    int           len;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   frames_seen = 0;

  uart_tx_fifo #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .tx_en_i(tx_en), .clks_per_bit_i(cpb),
    .data_bits_i(dbits), .parity_i(parity), .stop2_i(stop2),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
    .tx_o(tx), .busy_o(busy), .done_o(done), .level_o(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bits[0] is the first bit on the line; each bit lasts n cycles
  task automatic add_exp(input logic [15:0] bits, input int nb, input int n);
    exp_t e;
    e.wave = '0;
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < n; j++) e.wave[i*n+j] = bits[i];
    e.len = nb * n;
    expq.push_back(e);
  endtask

  task automatic monitor();
    logic [255:0] cap;
    int           clen;
    bit           capt;
    exp_t         e;
    cap = '0; clen = 0; capt = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: got done_o=1 expected no frame end");
        end else begin
          e = expq.pop_front();
          check("frame_len", clen, e.len);
          total++;
          if (cap !== e.wave) begin
            bad++;
            $display("FAIL frame_wave: got %h expected %h", cap, e.wave);
          end
        end
        frames_seen++;
        cap = '0; clen = 0; capt = 1'b0;
      end else if (capt && !busy) begin
        cap = '0; clen = 0; capt = 1'b0;
      end
      if (capt || (tx == 1'b0 && busy)) begin
        capt = 1'b1;
        if (clen < 256) cap[clen] = tx;
        clen++;
      end
    end
  endtask

  // Called at a negedge; returns 1 ns after the accepting posedge
  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int max);
    int k = 0;
    while (frames_seen < target && k < max) begin
      @(negedge clk);
      k++;
    end
    check("frames_done", frames_seen, target);
  endtask

  task automatic stimulus();
    int         base, accepted, w, gaps, dn, cyc;
    bit         started;
    logic [7:0] bytes [5];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;

    rst = 1'b1; tx_en = 1'b0; cpb = 16'd4; dbits = 2'd3; parity = 2'd0; stop2 = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tx_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_ready", in_ready, 1'b1);
      check("idle_level", level, 3'd0);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
    end

    // 0xA5, 8N1, N=4: start, 1,0,1,0,0,1,0,1, stop
    base = frames_seen;
    add_exp(16'b1101001010, 10, 4);
    push_byte(8'hA5);
    check("lat_level", level, 3'd1);
    check("lat_tx_high", tx, 1'b1);
    @(posedge clk); #1;
    check("lat_tx_low", tx, 1'b0);
    check("lat_busy", busy, 1'b1);
    check("lat_pop_level", level, 3'd0);
    wait_frames(base + 1, 100);

    // 0x03, 7 data bits, odd parity, 2 stop bits, N=2
    @(negedge clk);
    base = frames_seen;
    cpb = 16'd2; dbits = 2'd2; parity = 2'b10; stop2 = 1'b1;
`ifdef UART_TX_PARITY_EN
    add_exp(16'b11100000110, 11, 2);
`else
    add_exp(16'b1100000110, 10, 2);
`endif
    push_byte(8'h03);
    wait_frames(base + 1, 100);

    // 0xFF, 6 data bits (upper bits dropped), even parity, 1 stop bit, N=3
    @(negedge clk);
    base = frames_seen;
    cpb = 16'd3; dbits = 2'd1; parity = 2'b01; stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
    add_exp(16'b101111110, 9, 3);
`else
    add_exp(16'b11111110, 8, 3);
`endif
    push_byte(8'hFF);
    wait_frames(base + 1, 100);

    // Fill with transmitter disabled, then drain back to back (5N1, N=2)
    @(negedge clk);
    base = frames_seen;
    tx_en = 1'b0; cpb = 16'd2; dbits = 2'd0; parity = 2'd0; stop2 = 1'b0;
    add_exp(16'b1100010, 7, 2);
    add_exp(16'b1000100, 7, 2);
    add_exp(16'b1100110, 7, 2);
    add_exp(16'b1001000, 7, 2);
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = bytes[i];
      w = 0;
      while (!in_ready && w < 3) begin
        @(negedge clk);
        w++;
      end
      if (in_ready) begin
        @(posedge clk);
        accepted++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    check("full_accepted", accepted, 4);
    check("full_ready", in_ready, 1'b0);
    check("full_level", level, 3'd4);
    tx_en = 1'b1;
    started = 1'b0; gaps = 0; dn = 0; cyc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) dn++;
      if (dn == 4) break;
      if (busy) started = 1'b1;
      else if (started) gaps++;
      if (started) cyc++;
    end
    check("burst_dones", dn, 4);
    check("burst_gaps", gaps, 0);
    check("burst_cycles", cyc, 56);
    wait_frames(base + 4, 20);

    // Bit period changed mid-frame: 0x5A keeps N=4, 0xC3 uses N=8
    @(negedge clk);
    base = frames_seen;
    tx_en = 1'b0; cpb = 16'd4; dbits = 2'd3;
    add_exp(16'b1010110100, 10, 4);
    add_exp(16'b1110000110, 10, 8);
    push_byte(8'h5A);
    @(negedge clk);
    push_byte(8'hC3);
    @(negedge clk);
    tx_en = 1'b1;
    repeat (15) @(negedge clk);
    cpb = 16'd8;
    wait_frames(base + 2, 300);

    // Reset during DATA aborts the frame and empties the FIFO
    @(negedge clk);
    base = frames_seen;
    tx_en = 1'b0; cpb = 16'd4;
    push_byte(8'hA5);
    @(negedge clk);
    push_byte(8'h5A);
    @(negedge clk);
    tx_en = 1'b1;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_tx", tx, 1'b1);
    check("rst_level", level, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done || !tx) dn++;
    end
    check("rst_no_frame", dn, 0);
    check("rst_frames", frames_seen, base);
    check("queue_empty", expq.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, runtime-selectable frame format (5–8 data bits, optional parity, 1 or 2 stop bits) and a 16-bit baud divisor. It sits between the UART register interface, which pushes bytes through a valid/ready handshake, and the `tx` pad. It sends back-to-back frames with no idle gap while data is queued.

## Interface
Parameters:
- `DEPTH`, 4: number of FIFO entries. Power of two, 2 to 64.
- `LVL_W`, `$clog2(DEPTH)+1`: width of the FIFO level output.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `tx_en_i` in 1: when high, frames may start; when low, no new frame starts.
- `clks_per_bit_i` in 16: bit period in clock cycles (N). A value of 0 is treated as 1.
- `data_bits_i` in 2: data bits per frame; 0 → 5, 1 → 6, 2 → 7, 3 → 8.
- `parity_i` in 2: 00 none, 01 even, 10 odd, 11 none.
- `stop2_i` in 1: 0 → one stop bit, 1 → two stop bits.
- `in_valid_i` in 1: byte offered.
- `in_data_i` in 8: byte to send. Unused upper bits are ignored.
- `in_ready_o` out 1: FIFO not full.
- `tx_o` out 1: serial line. Idle level is 1.
- `busy_o` out 1: a frame is in progress.
- `done_o` out 1: one-cycle pulse at the end of each frame.
- `level_o` out LVL_W: current FIFO occupancy.

## Operation
- FIFO:
  - Push when `in_valid_i && in_ready_o`.
  - `in_ready_o = (level_o != DEPTH)`.
  - Pop happens only in the transmitter's load step.
  - Push and pop in the same cycle leave the level unchanged.
  - Read and write pointers wrap modulo DEPTH.
- States: IDLE, START, DATA, PARITY, STOP.
- Load step:
  - Taken from IDLE, or on the last cycle of STOP, when `tx_en_i` is high and the FIFO is non-empty.
  - Pops one entry into the shift register.
  - Latches `clks_per_bit_i`, `data_bits_i`, `parity_i` and `stop2_i` for the whole frame. Changes to these inputs mid-frame have no effect.
  - Moves to START.
- Bit timer:
  - Counter runs 0..N-1 in each bit. The bit ends when the counter equals N-1.
  - Counter is 16 bits and resets to 0 at every bit boundary.
- Frame sequence:
  - START: `tx_o` = 0.
  - DATA: bits sent LSB first; bit index runs 0..D-1, where D = data_bits_i + 5.
  - PARITY: sent only when parity is enabled. Value is the XOR of the D data bits, inverted for odd parity.
  - STOP: `tx_o` = 1 for one bit period, or two if `stop2_i` was latched high.
- End of STOP:
  - `done_o` = 1 for exactly one cycle.
  - If the load condition holds, go directly to START, so the next start bit follows with no gap.
  - Otherwise go to IDLE.
- `tx_en_i` low mid-frame: the current frame completes normally; no further load occurs.
- `busy_o` is high in every state except IDLE.
- Unreachable state encodings return to IDLE with `tx_o` = 1.

## Timing
- All outputs are registered.
- Reset values: `tx_o` = 1, `busy_o` = 0, `done_o` = 0, `level_o` = 0, `in_ready_o` = 1, state IDLE, all counters 0.
- Latency:
  - Push at edge t into an empty FIFO while idle and enabled: `level_o` = 1 after t.
  - Load at edge t+1: `tx_o` falls after t+1.
- Frame length is N·(1 + D + P + S) cycles, where P ∈ {0,1} and S ∈ {1,2}.
- `done_o` is asserted in the cycle after the edge that ends the last stop bit. The next frame's start bit (if any) begins at that same edge.
- Reset asserted mid-frame: at the next edge `tx_o` = 1, the FIFO is emptied and the frame is aborted. No `done_o` pulse is generated.
- Full FIFO: `in_ready_o` = 0 and the offered byte is held by the source. A pop in the same cycle does not create room until the following cycle.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: PARITY state and `parity_i` decoding are compiled in, as described above.
  - Undefined: the PARITY state and parity logic are absent, `parity_i` is ignored, and frames always have P = 0.

## Test plan
- Reset, then idle: `tx_o` = 1, `in_ready_o` = 1, `level_o` = 0, `busy_o` = 0 for 100 cycles.
- N = 4, 8N1, push 0xA5:
  - `tx_o` low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles.
  - Single `done_o` pulse; frame is 40 cycles.
- With `UART_TX_PARITY_EN` defined, N = 2, 7 data bits, odd parity, 2 stop bits, push 0x03:
  - Data 1,1,0,0,0,0,0, then parity 1, then 4 cycles high.
  - Frame is 22 cycles.
- DEPTH = 4, `tx_en_i` = 0, push 5 bytes:
  - 4 accepted; `in_ready_o` = 0 with `level_o` = 4.
  - Raise `tx_en_i`: 4 frames back to back, no high gap between each stop bit and the next start bit, 4 `done_o` pulses.
- Mid-frame changes:
  - Change `clks_per_bit_i` from 4 to 8 during the DATA state: the current frame keeps 4 cycles per bit; the next frame uses 8.
  - Assert `rst_i` during DATA: `tx_o` = 1 next cycle, `level_o` = 0, no `done_o`.
